// File: rtl/mc_core_hs_if.sv
// Memory handshake bundle between the multicycle core and its memory or bus adapter.
// The core drives a request; the memory side completes it by raising mem_ready.
interface mc_core_hs_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mc_core_hs.sv
// Multicycle MIPS-subset core with a request/ready memory handshake.
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH; halt and illegal encodings park in HALT.
module mc_core_hs #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  mc_core_hs_if.master     bus,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instret,
  output logic [31:0]      pc
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]  state;
  logic        active;   // low in the reset cycle so no request leaks out while rst is asserted
  logic [31:0] ir, a, b, alu_out, mdr;
  logic [31:0] regs [0:31];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, rs_val, rt_val, alu_result;
  logic        legal, req, we, done;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : regs[rt];

  // Bus outputs follow the state directly so a zero-wait request completes in its first cycle.
  assign req  = active && (state == S_FETCH || state == S_MEM);
  assign we   = active && (state == S_MEM) && (op == OP_SW);
  assign done = req && bus.mem_ready;

  assign bus.mem_req   = req;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = !active             ? '0 :
                         (state == S_FETCH)  ? pc[ADDR_W-1:0] :
                         (state == S_MEM)    ? alu_out[ADDR_W-1:0] : '0;
  assign bus.mem_wdata = we ? b : 32'd0;
  assign halted        = (state == S_HALT);

  // Decode legality of the latched instruction.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a missing branch would otherwise infer a latch.
    legal = 1'b0;
    case (op)
      OP_RTYPE: legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  // ALU: R-type selects by funct; everything else computes A + sext(imm).
  always_comb begin
    alu_result = a + imm_sext;
    if (op == OP_RTYPE) begin
      case (funct)
        F_ADD:   alu_result = a + b;
        F_SUB:   alu_result = a - b;
        F_AND:   alu_result = a & b;
        F_OR:    alu_result = a | b;
        F_SLT:   alu_result = {31'd0, ($signed(a) < $signed(b))};
        default: alu_result = 32'd0;
      endcase
    end
  end

  // Write-back port selection: rd for R-type, rt for addi/lw, MDR for lw.
  always_comb begin
    wb_en   = 1'b0;
    wb_addr = rd;
    wb_data = alu_out;
    if (state == S_WB) begin
      wb_en   = 1'b1;
      wb_addr = (op == OP_RTYPE) ? rd : rt;
      if (op == OP_LW) wb_data = mdr;
    end
  end

  // Register file; writes to $0 are dropped and reset suppresses any pending write.
  always_ff @(posedge clk) begin
    // NOTE: the register array has no reset; its contents are undefined until software writes them.
    if (rst && wb_en && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
  end

  // Control FSM and architectural state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
    if (!rst) begin
      state   <= S_FETCH;
      active  <= 1'b0;
      pc      <= RESET_PC;
      instret <= '0;
      err     <= 1'b0;
      ir      <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
    end else begin
      active <= 1'b1;
      case (state)
        S_FETCH: begin
          if (done) begin
            ir    <= bus.mem_rdata;
            pc    <= pc + 32'd4;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a <= rs_val;
          b <= rt_val;
          if (op == OP_HALT) begin
            state <= S_HALT;
          end else if (!legal) begin
            err   <= 1'b1;
            state <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (op)
            OP_LW, OP_SW: begin
              alu_out <= alu_result;
              state   <= S_MEM;
            end
            OP_BEQ: begin
              if (a == b) pc <= pc + (imm_sext << 2);
              instret <= instret + CNT_ONE;
              state   <= S_FETCH;
            end
            OP_J: begin
              pc      <= {pc[31:28], ir[25:0], 2'b00};
              instret <= instret + CNT_ONE;
              state   <= S_FETCH;
            end
            default: begin
              alu_out <= alu_result;
              state   <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (done) begin
            if (op == OP_SW) begin
              instret <= instret + CNT_ONE;
              state   <= S_FETCH;
            end else begin
              mdr   <= bus.mem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          instret <= instret + CNT_ONE;
          state   <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_core_hs.sv
// Directed bench for mc_core_hs: a word memory model with programmable wait states
// answers the handshake; programs are hand-assembled and results read back from memory.
module tb_mc_core_hs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halted, err;
  logic [15:0] instret;
  logic [31:0] pc;

  mc_core_hs_if #(.ADDR_W(32)) bus ();

  mc_core_hs #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .halted  (halted),
    .err     (err),
    .instret (instret),
    .pc      (pc)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:127];
  int          wait_n = 0;
  int          wcnt = 0;
  bit          in_wait = 1'b0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;
  int          stab_err = 0;
  logic [31:0] rd_log [0:63];
  logic [31:0] wr_addr_log [0:63];
  logic [31:0] wr_data_log [0:63];
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] HALT_W = {6'h3F, 26'd0};

  // Memory model: decides ready on the falling edge, so the core samples it on the next rising edge.
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (in_wait && (bus.mem_addr !== hold_addr || bus.mem_we !== hold_we ||
                      bus.mem_wdata !== hold_wdata))
        stab_err++;
      if (wcnt >= wait_n) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr[8:2]];
        if (bus.mem_we) begin
          mem[bus.mem_addr[8:2]] = bus.mem_wdata;
          if (wr_cnt < 64) begin
            wr_addr_log[wr_cnt] = bus.mem_addr;
            wr_data_log[wr_cnt] = bus.mem_wdata;
          end
          wr_cnt++;
        end else begin
          if (rd_cnt < 64) rd_log[rd_cnt] = bus.mem_addr;
          rd_cnt++;
        end
        wcnt    = 0;
        in_wait = 1'b0;
      end else begin
        bus.mem_ready = 1'b0;
        wcnt++;
        in_wait    = 1'b1;
        hold_addr  = bus.mem_addr;
        hold_we    = bus.mem_we;
        hold_wdata = bus.mem_wdata;
      end
    end else begin
      bus.mem_ready = 1'b0;
      wcnt    = 0;
      in_wait = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    rd_cnt   = 0;
    wr_cnt   = 0;
    stab_err = 0;
  endtask

  // Assert reset for one edge and check the reset-cycle outputs.
  task automatic reset_core();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_req",     {31'd0, bus.mem_req}, 32'd0);
    check("rst_we",      {31'd0, bus.mem_we}, 32'd0);
    check("rst_addr",    bus.mem_addr, 32'd0);
    check("rst_wdata",   bus.mem_wdata, 32'd0);
    check("rst_pc",      pc, 32'd0);
    check("rst_instret", {16'd0, instret}, 32'd0);
    check("rst_halted",  {31'd0, halted}, 32'd0);
    check("rst_err",     {31'd0, err}, 32'd0);
  endtask

  // Release reset; the first request must appear in the following cycle at RESET_PC.
  task automatic release_core();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("first_req",  {31'd0, bus.mem_req}, 32'd1);
    check("first_addr", bus.mem_addr, 32'd0);
  endtask

  // Count rising edges from the first request until halted, bounded.
  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic load_arith();
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);      // addi $1,$0,5
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);   // addi $2,$0,-3
    mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);       // add  $3,$1,$2
    mem[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);       // slt  $4,$2,$1
    mem[4] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0080);   // sw   $3,0x80($0)
    mem[5] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0084);   // sw   $4,0x84($0)
    mem[6] = HALT_W;
  endtask

  int cyc;
  int bad_req;

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;

    // Arithmetic program, zero wait states.
    wait_n = 0;
    reset_core();
    load_arith();
    release_core();
    run_to_halt(cyc);
    check("arith_cycles",  cyc, 32'd26);
    check("arith_r3",      mem[32], 32'd2);
    check("arith_r4",      mem[33], 32'd1);
    check("arith_instret", {16'd0, instret}, 32'd6);
    check("arith_err",     {31'd0, err}, 32'd0);
    check("arith_wr_cnt",  wr_cnt, 32'd2);
    check("arith_wr_addr", wr_addr_log[0], 32'h80);

    // Same program, three wait states on every one of its nine requests.
    wait_n = 3;
    reset_core();
    load_arith();
    release_core();
    run_to_halt(cyc);
    check("wait_cycles",   cyc, 32'd53);
    check("wait_r3",       mem[32], 32'd2);
    check("wait_r4",       mem[33], 32'd1);
    check("wait_instret",  {16'd0, instret}, 32'd6);
    check("wait_stable",   stab_err, 32'd0);

    // Store, load, and writes to $0.
    wait_n = 0;
    reset_core();
    clear_mem();
    mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);     // addi $1,$0,5
    mem[1]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);     // addi $0,$0,7
    mem[2]  = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);     // sw   $1,8($0)
    mem[3]  = enc_i(6'h23, 5'd0, 5'd5, 16'd8);     // lw   $5,8($0)
    mem[4]  = enc_i(6'h2B, 5'd0, 5'd5, 16'h0080);  // sw   $5,0x80($0)
    mem[5]  = enc_i(6'h2B, 5'd0, 5'd0, 16'h0084);  // sw   $0,0x84($0)
    mem[6]  = HALT_W;
    mem[33] = 32'hDEAD_BEEF;
    release_core();
    run_to_halt(cyc);
    check("ls_wr_cnt",   wr_cnt, 32'd3);
    check("ls_wr0_addr", wr_addr_log[0], 32'd8);
    check("ls_wr0_data", wr_data_log[0], 32'd5);
    check("ls_r5",       mem[32], 32'd5);
    check("ls_r0",       mem[33], 32'd0);
    check("ls_instret",  {16'd0, instret}, 32'd6);

    // Branches and jump: fetch address trace.
    reset_core();
    clear_mem();
    mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd1);     // addi $1,$0,1
    mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd1);     // addi $2,$0,1
    mem[2]  = enc_i(6'h08, 5'd0, 5'd3, 16'd2);     // addi $3,$0,2
    mem[3]  = enc_i(6'h04, 5'd1, 5'd3, 16'd5);     // 0x0C beq $1,$3,5 (not taken)
    mem[4]  = enc_i(6'h04, 5'd1, 5'd2, 16'd2);     // 0x10 beq $1,$2,2 (taken)
    mem[5]  = HALT_W;
    mem[6]  = HALT_W;
    mem[7]  = {6'h02, 26'h40};                     // 0x1C j 0x40
    mem[64] = HALT_W;                              // 0x100
    release_core();
    run_to_halt(cyc);
    check("br_rd_cnt", rd_cnt, 32'd7);
    check("br_f3",     rd_log[3], 32'h0C);
    check("br_f4",     rd_log[4], 32'h10);
    check("br_f5",     rd_log[5], 32'h1C);
    check("br_f6",     rd_log[6], 32'h100);
    check("br_pc",     pc, 32'h104);
    check("br_instret", {16'd0, instret}, 32'd6);
    check("br_err",    {31'd0, err}, 32'd0);

    // Illegal opcode 0x3E.
    reset_core();
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    mem[1] = {6'h3E, 26'd0};
    release_core();
    run_to_halt(cyc);
    check("ill_err",     {31'd0, err}, 32'd1);
    check("ill_instret", {16'd0, instret}, 32'd1);
    bad_req = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req !== 1'b0 || halted !== 1'b1) bad_req++;
    end
    check("ill_quiet",   bad_req, 32'd0);
    check("ill_rd_cnt",  rd_cnt, 32'd2);

    // Illegal funct under op 0.
    reset_core();
    clear_mem();
    mem[0] = enc_r(5'd0, 5'd0, 5'd1, 6'h21);
    release_core();
    run_to_halt(cyc);
    check("fn_err",     {31'd0, err}, 32'd1);
    check("fn_instret", {16'd0, instret}, 32'd0);

    // Reset while the second fetch is stalled.
    wait_n = 0;
    reset_core();
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    mem[1] = enc_i(6'h08, 5'd0, 5'd1, 16'd2);
    mem[2] = HALT_W;
    release_core();
    @(posedge clk);
    #1;
    wait_n = 50;
    repeat (3) @(posedge clk);
    #1;
    check("pend_req",     {31'd0, bus.mem_req}, 32'd1);
    check("pend_addr",    bus.mem_addr, 32'd4);
    check("pend_instret", {16'd0, instret}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_req",     {31'd0, bus.mem_req}, 32'd0);
    check("abort_pc",      pc, 32'd0);
    check("abort_instret", {16'd0, instret}, 32'd0);
    wait_n = 0;
    release_core();
    run_to_halt(cyc);
    check("restart_instret", {16'd0, instret}, 32'd2);
    check("restart_err",     {31'd0, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
